// File: rtl/asip_pkg.sv
// Shared constants and types for the ASIP writeback sinks.
// The audio serializer's frame geometry and FSM states are defined here.
package asip_pkg;

    localparam int DATA_W = 24;
    localparam int REG_W = 6;
    localparam logic [REG_W-1:0] OUT_REG = 6'd63;
    localparam int FRAME_BITS = 48;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } serState_e;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO. rdData is registered on pop and returns zero when
// a pop finds the FIFO empty, so the consumer sees a silent sample.
module sample_fifo #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wrData,
    output logic [DATA_W-1:0]        rdData,
    output logic [DATA_W-1:0]        headData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wrPtr;
    logic [AW-1:0]     rdPtr;
    logic              pushEff;
    logic              popEff;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign popEff   = pop && !empty;
    // A push into a full FIFO still lands when the same cycle frees a slot.
    assign pushEff  = push && (!full || popEff);
    assign headData = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (pushEff) begin
            mem[wrPtr] <= wrData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            count  <= '0;
            rdData <= '0;
        end else begin
            if (pushEff) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (popEff) begin
                rdPtr  <= rdPtr + 1'b1;
                rdData <= mem[rdPtr];
            end else if (pop) begin
                rdData <= '0;
            end
            case ({pushEff, popEff})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/audio_out_serializer.sv
// Captures writebacks to the audio register and plays them out as a
// left-justified stereo stream, mono sample duplicated on both slots.
//
// state | meaning
// IDLE  | link quiet, bclk/lrclk/sdata held low, divider cleared
// RUN   | serializing 48-slot frames back to back
module audio_out_serializer
    import asip_pkg::*;
#(
    parameter int                DATA_W     = asip_pkg::DATA_W,
    parameter int                REG_W      = asip_pkg::REG_W,
    parameter logic [REG_W-1:0]  OUT_REG    = asip_pkg::OUT_REG,
    parameter int                FIFO_DEPTH = 8,
    parameter int                BCLK_DIV   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wb_valid,
    input  logic [REG_W-1:0]              wb_reg,
    input  logic [DATA_W-1:0]             wb_data,
    input  logic                          en,
    input  logic                          clr_flags,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          sdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          underflow,
    output logic                          busy
);

    localparam int                 DIV_W     = $clog2(BCLK_DIV);
    localparam int                 SLOT_W    = $clog2(FRAME_BITS);
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [SLOT_W-1:0]  SLOT_LAST = SLOT_W'(FRAME_BITS - 1);
    localparam logic [SLOT_W-1:0]  SLOT_HALF = SLOT_W'(FRAME_BITS / 2 - 1);

    serState_e          state;
    serState_e          nextState;
    logic               pushReq;
    logic               popReq;
    logic               startFrame;
    logic               stopFrame;
    logic               fallEdge;
    logic               frameEnd;
    logic               fifoFull;
    logic               fifoEmpty;
    logic               ovfEvent;
    logic               udfEvent;
    logic [DATA_W-1:0]  headData;
    logic [DATA_W-1:0]  heldSample;
    logic [DATA_W-1:0]  loadVal;
    logic [DATA_W-2:0]  shiftReg;
    logic [DIV_W-1:0]   divCnt;
    logic [SLOT_W-1:0]  slotCnt;

    sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (pushReq),
        .pop      (popReq),
        .wrData   (wb_data),
        .rdData   (heldSample),
        .headData (headData),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifo_count)
    );

    assign pushReq  = wb_valid && (wb_reg == OUT_REG);
    assign fallEdge = (state == RUN) && (divCnt == DIV_LAST) && bclk;
    assign frameEnd = fallEdge && (slotCnt == SLOT_LAST);
    assign loadVal  = fifoEmpty ? '0 : headData;
    assign ovfEvent = pushReq && fifoFull && !popReq;
    assign udfEvent = (state == RUN) && startFrame && fifoEmpty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= nextState;
            busy  <= (nextState == RUN);
        end
    end

    always_comb begin
        nextState  = state;
        popReq     = 1'b0;
        startFrame = 1'b0;
        stopFrame  = 1'b0;
        case (state)
            IDLE: begin
                if (en && !fifoEmpty) begin
                    nextState  = RUN;
                    popReq     = 1'b1;
                    startFrame = 1'b1;
                end
            end
            RUN: begin
                if (frameEnd) begin
                    if (en) begin
                        // Pop even when empty: the FIFO hands back zero for the hold register.
                        popReq     = 1'b1;
                        startFrame = 1'b1;
                    end else begin
                        nextState  = IDLE;
                        stopFrame  = 1'b1;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || stopFrame) begin
            divCnt   <= '0;
            slotCnt  <= '0;
            shiftReg <= '0;
            bclk     <= 1'b0;
            lrclk    <= 1'b0;
            sdata    <= 1'b0;
        end else if (startFrame) begin
            divCnt   <= '0;
            slotCnt  <= '0;
            shiftReg <= loadVal[DATA_W-2:0];
            bclk     <= 1'b0;
            lrclk    <= 1'b0;
            sdata    <= loadVal[DATA_W-1];
        end else if (state == RUN) begin
            if (divCnt == DIV_LAST) begin
                divCnt <= '0;
                bclk   <= ~bclk;
                if (bclk) begin
                    slotCnt <= slotCnt + 1'b1;
                    if (slotCnt == SLOT_HALF) begin
                        shiftReg <= heldSample[DATA_W-2:0];
                        sdata    <= heldSample[DATA_W-1];
                        lrclk    <= 1'b1;
                    end else begin
                        shiftReg <= {shiftReg[DATA_W-3:0], 1'b0};
                        sdata    <= shiftReg[DATA_W-2];
                    end
                end
            end else begin
                divCnt <= divCnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovfEvent) begin
                overflow <= 1'b1;
            end else if (clr_flags) begin
                overflow <= 1'b0;
            end
            if (udfEvent) begin
                underflow <= 1'b1;
            end else if (clr_flags) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audio_out_serializer.sv
// Directed bench for audio_out_serializer with a sample scoreboard; expected
// frames come from the queue of accepted writebacks.
module tb_audio_out_serializer;

    localparam int DIV    = 2;
    localparam int DEPTH  = 8;
    localparam int FRAME_CYC = 96 * DIV;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic [5:0]  wb_reg;
    logic [23:0] wb_data;
    logic        en;
    logic        clr_flags;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic        underflow;
    logic        busy;

    int passCnt  = 0;
    int totalCnt = 0;
    int failCnt  = 0;
    logic [23:0] sb[$];

    audio_out_serializer #(
        .FIFO_DEPTH (DEPTH),
        .BCLK_DIV   (DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_valid   (wb_valid),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .en         (en),
        .clr_flags  (clr_flags),
        .bclk       (bclk),
        .lrclk      (lrclk),
        .sdata      (sdata),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .underflow  (underflow),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pushWb(input logic [5:0] r, input logic v, input logic [23:0] d);
        wb_valid = v;
        wb_reg   = r;
        wb_data  = d;
        if (v && r == 6'd63 && sb.size() < DEPTH) sb.push_back(d);
        @(negedge clk);
        wb_valid = 1'b0;
    endtask

    task automatic waitBusy(input string tag, input int expLat);
        int n = 0;
        while (busy !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(n), 64'(expLat));
    endtask

    // Called at the first cycle of a frame; returns at the first cycle after it.
    task automatic runFrame(input string tag, input int dropEnAt);
        logic [23:0] exp;
        logic [47:0] gotData;
        logic [47:0] gotLr;
        logic        curD;
        logic        curL;
        int          timingErr;
        exp = (sb.size() != 0) ? sb.pop_front() : 24'h0;
        gotData = '0;
        gotLr = '0;
        curD = 1'b0;
        curL = 1'b0;
        timingErr = 0;
        for (int k = 0; k < FRAME_CYC; k++) begin
            if (bclk !== ((k % (2 * DIV)) >= DIV)) timingErr++;
            if (busy !== 1'b1) timingErr++;
            if (k % (2 * DIV) == 0) begin
                curD = sdata;
                curL = lrclk;
                gotData[47 - k / (2 * DIV)] = sdata;
                gotLr[47 - k / (2 * DIV)] = lrclk;
            end else if (sdata !== curD || lrclk !== curL) begin
                timingErr++;
            end
            if (k == dropEnAt * 2 * DIV) en = 1'b0;
            @(negedge clk);
        end
        check({tag, "_sdata"}, 64'(gotData), 64'({exp, exp}));
        check({tag, "_lrclk"}, 64'(gotLr), 64'({24'h0, 24'hFFFFFF}));
        check({tag, "_timing"}, 64'(timingErr), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        wb_valid = 1'b0;
        wb_reg = '0;
        wb_data = '0;
        en = 1'b0;
        clr_flags = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({bclk, lrclk, sdata, busy, overflow, underflow, fifo_count}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single sample, then an underflow frame, en dropped at slot 10.
        en = 1'b1;
        pushWb(6'd63, 1'b1, 24'hA5A5A5);
        check("push_count", 64'(fifo_count), 64'd1);
        check("busy_before_run", 64'(busy), 64'd0);
        waitBusy("run_latency", 1);
        check("run_entry", 64'({busy, sdata, lrclk, bclk, fifo_count}), 64'({4'b1100, 4'd0}));
        check("no_underflow_yet", 64'(underflow), 64'd0);
        runFrame("frame_a5", -1);
        check("underflow_at_boundary", 64'({underflow, busy}), 64'b11);
        runFrame("frame_zero", 10);
        check("idle_after_drop", 64'({busy, bclk, lrclk, sdata}), 64'd0);
        repeat (5) @(negedge clk);
        check("idle_stays", 64'({busy, bclk, lrclk, sdata}), 64'd0);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("underflow_clr", 64'(underflow), 64'd0);

        // Writebacks that must not be captured.
        en = 1'b1;
        pushWb(6'd5, 1'b1, 24'h123456);
        pushWb(6'd63, 1'b0, 24'h654321);
        @(negedge clk);
        check("ignored_count", 64'(fifo_count), 64'd0);
        check("ignored_busy", 64'(busy), 64'd0);
        en = 1'b0;

        // Fill past capacity, then a set/clear collision.
        for (int i = 0; i < 9; i++) pushWb(6'd63, 1'b1, 24'(24'h5A0000 ^ (i * 24'h013579)));
        check("full_count", 64'(fifo_count), 64'd8);
        check("overflow_set", 64'(overflow), 64'd1);
        clr_flags = 1'b1;
        pushWb(6'd63, 1'b1, 24'hFFFFFF);
        clr_flags = 1'b0;
        check("overflow_set_wins", 64'({overflow, fifo_count}), 64'({1'b1, 4'd8}));
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("overflow_clr", 64'(overflow), 64'd0);

        // Back-to-back frames from the full FIFO, then reset mid-frame.
        en = 1'b1;
        waitBusy("run_latency_full", 1);
        runFrame("frame_s0", -1);
        runFrame("frame_s1", -1);
        check("count_after_pops", 64'(fifo_count), 64'd5);
        repeat (30 * 2 * DIV) @(negedge clk);
        check("busy_mid_frame", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_frame", 64'({bclk, lrclk, sdata, busy, overflow, underflow, fifo_count}), 64'd0);
        reset = 1'b0;
        sb.delete();
        repeat (4) @(negedge clk);
        check("idle_after_reset", 64'({busy, bclk, fifo_count}), 64'd0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
